// File: rtl/pc_stack_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : bip_pc_pkg
// Brief  : Shared opcode encodings for the BIP program counter unit.
// Rev    : 1.0 - initial release
// ============================================================================
package bip_pc_pkg;

    localparam int PC_OP_W = 2;

    typedef logic [PC_OP_W-1:0] pc_op_t;

    localparam pc_op_t PC_OP_INC  = 2'b00;
    localparam pc_op_t PC_OP_JUMP = 2'b01;
    localparam pc_op_t PC_OP_CALL = 2'b10;
    localparam pc_op_t PC_OP_RET  = 2'b11;

endpackage : bip_pc_pkg
`default_nettype wire

// File: rtl/pc_stack_unit_if.sv
`default_nettype none
// ============================================================================
// Module : pc_stack_unit_if
// Brief  : Decoder-side bus of the PC/return-stack unit.
// Rev    : 1.0 - initial release
// ============================================================================
interface pc_stack_unit_if
    import bip_pc_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 8
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic               enable_i;
    pc_op_t             op_i;
    logic [ADDR_W-1:0]  target_i;
    logic               clear_flags_i;
    logic [ADDR_W-1:0]  pc_o;
    logic [DEPTH_W-1:0] depth_o;
    logic               stack_full_o;
    logic               stack_empty_o;
    logic               overflow_o;
    logic               underflow_o;

    // Decoder side: issues operations, observes the PC and stack status
    modport master (
        output enable_i, op_i, target_i, clear_flags_i,
        input  pc_o, depth_o, stack_full_o, stack_empty_o, overflow_o, underflow_o
    );

    // PC unit side
    modport slave (
        input  enable_i, op_i, target_i, clear_flags_i,
        output pc_o, depth_o, stack_full_o, stack_empty_o, overflow_o, underflow_o
    );

endinterface : pc_stack_unit_if
`default_nettype wire

// File: rtl/pc_stack_unit_return_stack.sv
`default_nettype none
// ============================================================================
// Module : return_stack
// Brief  : LIFO of return addresses; push ignored when full, pop when empty.
// Rev    : 1.0 - initial release
// ============================================================================
module return_stack #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 8
) (
    input  wire logic                         clock_i,
    input  wire logic                         reset_i,
    input  wire logic                         push_i,
    input  wire logic                         pop_i,
    input  wire logic [ADDR_W-1:0]            data_i,
    output logic      [ADDR_W-1:0]            top_o,
    output logic      [$clog2(DEPTH+1)-1:0]   depth_o,
    output logic                              full_o,
    output logic                              empty_o
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_full = PTR_W'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic              w_do_push;
    logic              w_do_pop;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;

    assign full_o    = (r_ptr == c_ptr_full);
    assign empty_o   = (r_ptr == '0);
    assign depth_o   = r_ptr;
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o & ~push_i;

    // The pointer always names the next free slot; the top lives one below it.
    // Out-of-range indices only arise when full (no write) or empty (top unused).
    assign w_wr_idx = IDX_W'(r_ptr);
    assign w_rd_idx = IDX_W'(r_ptr - PTR_W'(1));
    assign top_o    = r_mem[w_rd_idx];

    // Stack pointer: the only state that must be reset
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_ptr <= '0;
        end else if (w_do_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - PTR_W'(1);
        end
    end

    // Entry storage, contents are don't-care after reset
    always_ff @(posedge clock_i) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= data_i;
        end
    end

endmodule : return_stack
`default_nettype wire

// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module : pc_stack_unit
// Brief  : Program counter with CALL/RETURN stack and sticky error flags.
// Rev    : 1.0 - initial release
// ============================================================================
module pc_stack_unit
    import bip_pc_pkg::*;
#(
    parameter int                ADDR_W     = 11,
    parameter int                DEPTH      = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  wire logic       clock_i,
    input  wire logic       reset_i,
    pc_stack_unit_if.slave  bus
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_top;
    logic [DEPTH_W-1:0] w_depth;
    logic               w_full;
    logic               w_empty;
    logic               w_is_call;
    logic               w_is_ret;
    logic               w_ovf_set;
    logic               w_udf_set;
    logic               r_overflow;
    logic               r_underflow;

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_is_call = bus.enable_i && (bus.op_i == PC_OP_CALL);
    assign w_is_ret  = bus.enable_i && (bus.op_i == PC_OP_RET);
    assign w_ovf_set = w_is_call && w_full;
    assign w_udf_set = w_is_ret && w_empty;

    return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_return_stack (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (w_is_call),
        .pop_i   (w_is_ret),
        .data_i  (w_pc_inc),
        .top_o   (w_top),
        .depth_o (w_depth),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Next-PC selection; a RETURN on an empty stack just falls through
    always_comb begin
        w_pc_next = r_pc;
        if (bus.enable_i) begin
            case (bus.op_i)
                PC_OP_INC:  w_pc_next = w_pc_inc;
                PC_OP_JUMP: w_pc_next = bus.target_i;
                PC_OP_CALL: w_pc_next = bus.target_i;
                PC_OP_RET:  w_pc_next = w_empty ? w_pc_inc : w_top;
                default:    w_pc_next = r_pc;
            endcase
        end
    end

    // PC register
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pc <= RESET_ADDR;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Sticky error flags; a new error takes priority over a clear request
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_flags_i) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (bus.clear_flags_i) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.depth_o       = w_depth;
    assign bus.stack_full_o  = w_full;
    assign bus.stack_empty_o = w_empty;
    assign bus.overflow_o    = r_overflow;
    assign bus.underflow_o   = r_underflow;

endmodule : pc_stack_unit
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_stack_unit
// Brief  : Directed self-checking bench for pc_stack_unit.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pc_stack_unit;
    import bip_pc_pkg::*;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 8;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_stack_unit_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    pc_stack_unit #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .RESET_ADDR (11'h000)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply one operation, let one rising edge sample it, settle 1 time unit
    task automatic do_op(input logic en, input pc_op_t op, input logic [ADDR_W-1:0] tgt,
                         input logic clr);
        bus.enable_i      = en;
        bus.op_i          = op;
        bus.target_i      = tgt;
        bus.clear_flags_i = clr;
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [ADDR_W-1:0] pc,
                               input int depth, input logic ovf, input logic udf);
        check({tag, "_pc"},    32'(bus.pc_o),        32'(pc));
        check({tag, "_depth"}, 32'(bus.depth_o),     32'(depth));
        check({tag, "_ovf"},   32'(bus.overflow_o),  32'(ovf));
        check({tag, "_udf"},   32'(bus.underflow_o), 32'(udf));
    endtask

    // Return addresses pushed by the 8 overflow-test CALLs (first from pc=6)
    logic [ADDR_W-1:0] exp_ret [8];
    logic [ADDR_W-1:0] call_tgt [8];

    initial begin
        exp_ret  = '{11'h007, 11'h021, 11'h031, 11'h041, 11'h051, 11'h061, 11'h071, 11'h081};
        call_tgt = '{11'h020, 11'h030, 11'h040, 11'h050, 11'h060, 11'h070, 11'h080, 11'h090};

        bus.enable_i      = 1'b0;
        bus.op_i          = PC_OP_INC;
        bus.target_i      = '0;
        bus.clear_flags_i = 1'b0;

        // Reset state
        #1;
        check_state("rst", 11'h000, 0, 1'b0, 1'b0);
        check("rst_empty", 32'(bus.stack_empty_o), 32'd1);
        check("rst_full",  32'(bus.stack_full_o),  32'd0);
        repeat (2) @(posedge clock_i);
        #1;
        reset_i = 1'b1;

        // 1. Asynchronous reset between edges, then INC x3
        do_op(1'b1, PC_OP_INC, '0, 1'b0);
        do_op(1'b1, PC_OP_INC, '0, 1'b0);
        check("pre_areset_pc", 32'(bus.pc_o), 32'h2);
        #3 reset_i = 1'b0;
        #1 check("areset_pc", 32'(bus.pc_o), 32'h0);
        #2 reset_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            do_op(1'b1, PC_OP_INC, '0, 1'b0);
            check_state("inc", 11'(i), 0, 1'b0, 1'b0);
        end

        // 2. Nested call/return
        do_op(1'b1, PC_OP_JUMP, 11'h005, 1'b0);
        check("jump_pc", 32'(bus.pc_o), 32'h005);
        do_op(1'b1, PC_OP_CALL, 11'h100, 1'b0);
        check_state("call1", 11'h100, 1, 1'b0, 1'b0);
        do_op(1'b1, PC_OP_INC, '0, 1'b0);
        check("inc_in_sub", 32'(bus.pc_o), 32'h101);
        do_op(1'b1, PC_OP_CALL, 11'h200, 1'b0);
        check_state("call2", 11'h200, 2, 1'b0, 1'b0);
        do_op(1'b1, PC_OP_RET, '0, 1'b0);
        check_state("ret2", 11'h102, 1, 1'b0, 1'b0);
        do_op(1'b1, PC_OP_RET, '0, 1'b0);
        check_state("ret1", 11'h006, 0, 1'b0, 1'b0);
        check("ret1_empty", 32'(bus.stack_empty_o), 32'd1);

        // 3. Fill, overflow, unwind
        for (int i = 0; i < 8; i++) begin
            do_op(1'b1, PC_OP_CALL, call_tgt[i], 1'b0);
            check("fill_pc",    32'(bus.pc_o),    32'(call_tgt[i]));
            check("fill_depth", 32'(bus.depth_o), 32'(i + 1));
        end
        check("full_flag",  32'(bus.stack_full_o),  32'd1);
        check("full_empty", 32'(bus.stack_empty_o), 32'd0);
        do_op(1'b1, PC_OP_CALL, 11'h7F0, 1'b0);
        check_state("ovf", 11'h7F0, 8, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            do_op(1'b1, PC_OP_RET, '0, 1'b0);
            check("unwind_pc",    32'(bus.pc_o),    32'(exp_ret[i]));
            check("unwind_depth", 32'(bus.depth_o), 32'(i));
        end
        do_op(1'b0, PC_OP_INC, '0, 1'b1);
        check_state("ovf_clr", 11'h007, 0, 1'b0, 1'b0);

        // 4. Underflow, clear, and set-beats-clear
        do_op(1'b1, PC_OP_JUMP, 11'h010, 1'b0);
        do_op(1'b1, PC_OP_RET, '0, 1'b0);
        check_state("udf", 11'h011, 0, 1'b0, 1'b1);
        do_op(1'b0, PC_OP_RET, '0, 1'b1);
        check_state("udf_clr", 11'h011, 0, 1'b0, 1'b0);
        do_op(1'b1, PC_OP_RET, '0, 1'b1);
        check_state("udf_setwins", 11'h012, 0, 1'b0, 1'b1);

        // 5. Wrap and hold
        do_op(1'b1, PC_OP_JUMP, 11'h7FF, 1'b0);
        do_op(1'b1, PC_OP_INC, '0, 1'b0);
        check("wrap_inc", 32'(bus.pc_o), 32'h000);
        do_op(1'b1, PC_OP_JUMP, 11'h7FF, 1'b0);
        do_op(1'b1, PC_OP_CALL, 11'h050, 1'b0);
        check_state("wrap_call", 11'h050, 1, 1'b0, 1'b1);
        do_op(1'b1, PC_OP_RET, '0, 1'b0);
        check_state("wrap_ret", 11'h000, 0, 1'b0, 1'b1);
        do_op(1'b1, PC_OP_CALL, 11'h300, 1'b0);
        do_op(1'b0, PC_OP_CALL, 11'h123, 1'b0);
        check_state("hold", 11'h300, 1, 1'b0, 1'b1);

        // 6. Reset mid-operation at depth 3
        do_op(1'b1, PC_OP_CALL, 11'h310, 1'b0);
        do_op(1'b1, PC_OP_CALL, 11'h320, 1'b0);
        check_state("pre_rst", 11'h320, 3, 1'b0, 1'b1);
        #3 reset_i = 1'b0;
        #1 check_state("mid_rst", 11'h000, 0, 1'b0, 1'b0);
        #2 reset_i = 1'b1;
        do_op(1'b1, PC_OP_RET, '0, 1'b0);
        check_state("post_rst_ret", 11'h001, 0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_stack_unit
`default_nettype wire
